store_rmw_ctrl: RTL and testbench
=================================

Name: store_rmw_ctrl

Overview:
- Sequences store instructions (SB/SH/SW) onto a word-wide data memory for the RISC-V datapath.
- Aligned word stores are written directly.
- Byte and halfword stores use a read-modify-write: read the word, merge the new byte lanes, write it back.
- Sits between the execute/memory stage and data memory; it owns the memory port while Busy=1.

Parameters:
- ADDR_W, 32: byte-address width.
- MEM_LAT, 1: memory read latency in cycles; legal range 1..4.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Req  in  1  store request; sampled only when Busy=0.
- Funct3  in  3  store size: 000 SB, 001 SH, 010 SW; any other value is illegal.
- Addr  in  ADDR_W  byte address.
- Dato  in  32  store data; SB uses [7:0], SH uses [15:0].
- Busy  out  1  controller is processing a request.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle error flag; asserted only together with Done.
- Mem_Addr  out  ADDR_W  word address: {Addr[ADDR_W-1:2], 2'b00}.
- Mem_RE  out  1  memory read strobe.
- Mem_WE  out  1  memory write strobe.
- Mem_WData  out  32  write data.
- Mem_RData  in  32  read data.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - Busy, Done, Err, Mem_RE, Mem_WE = 0; Mem_Addr = 0; Mem_WData = 0; all internal latches = 0.
- All outputs are registered.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - Busy=0.
  - On Req=1, latch Funct3/Addr/Dato, load Mem_Addr, Busy=1 from the next cycle.
  - Next state:
    - Funct3=010 with Addr[1:0]=00 -> WRITE.
    - Legal SB/SH -> READ.
    - Otherwise (illegal Funct3, SH with Addr[0]=1, SW with Addr[1:0]!=00) -> DONE with error; no memory access at all.
- READ: Mem_RE=1 for exactly 1 cycle -> WAIT.
- WAIT:
  - Lasts MEM_LAT cycles.
  - Mem_RData is valid in the last WAIT cycle and is captured at the end of it -> WRITE.
- WRITE:
  - Mem_WE=1 for exactly 1 cycle.
  - Mem_WData = merged word for SB/SH, or latched Dato for SW.
  - Next -> DONE.
- DONE:
  - Done=1 for 1 cycle; Err=1 if the request was illegal.
  - Busy remains 1 in this cycle -> IDLE.
- Busy=1 in every state except IDLE.
- A new Req is accepted in the cycle after DONE at the earliest.
- Merge rules, with k=Addr[1:0] and word W read from memory:
  - SB: W[8k+7:8k] <= Dato[7:0]; all other bytes unchanged.
  - SH: W[16h+15:16h] <= Dato[15:0], where h=Addr[1]; other half unchanged.
- Mem_WData is 0 outside WRITE.
- Mem_Addr holds its value from acceptance until the next acceptance.
- Latency, counted from the accepting edge:
  - SW: WRITE in cycle 1, Done in cycle 2.
  - SB/SH: READ in cycle 1, WAIT in cycles 2..1+MEM_LAT, WRITE in cycle 2+MEM_LAT, Done in cycle 3+MEM_LAT.
  - Error: Done+Err in cycle 1.
- Req and input changes while Busy=1 are ignored: not queued, and the latched fields are not disturbed.
- Req held high across DONE is treated as a new request once back in IDLE.
- Reset mid-operation:
  - Immediate return to IDLE, outputs cleared, pending write dropped.
  - Mem_WE is never asserted after RST rises unless a new request is accepted after reset release.
- Mem_RE and Mem_WE are never high in the same cycle.

Test Plan:
- Memory model: MEM_LAT=1, word at 0x100 = 0x11223344 restored before each case.
1. SW, Addr=0x100, Dato=0xABCDEF17 -> no Mem_RE; Mem_WE for 1 cycle with Mem_Addr=0x100 and Mem_WData=0xABCDEF17; Done in cycle 2, Err=0.
2. SB, Addr=0x100..0x103, Dato=0xABCDEF17 -> one Mem_RE, then Mem_WData = 0x11223317, 0x11221744, 0x11172344, 0x17223344 respectively; Done in cycle 4.
3. SH, Addr=0x100 -> 0x1122EF17; Addr=0x102 -> 0xEF173344. SH at Addr=0x103, SW at Addr=0x102, and Funct3=100 each -> Done+Err in cycle 1, no Mem_RE/Mem_WE.
4. Req held high and Addr/Dato changed during a busy SB -> exactly one Mem_WE, using the originally latched values. A second request is accepted in the cycle after DONE.
5. RST asserted during WAIT -> all outputs 0 on assertion, no Mem_WE afterwards. After release, an SW completes normally.
6. MEM_LAT=3, SB at Addr=0x101 -> WAIT lasts 3 cycles; Mem_RData captured from the third WAIT cycle; Mem_WData=0x11221744; Done in cycle 6.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sequences RISC-V SB/SH/SW stores onto a word-wide data memory.
// Aligned SW is written directly. SB and SH perform a read-modify-write:
// read the word, merge the new byte lanes, then write the word back.
// Illegal requests finish with Done+Err and make no memory access.
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   Req/Funct3/Addr/Dato  store request, sampled only while Busy=0
//   Busy/Done/Err       status; Done is a one-cycle pulse, Err only qualifies Done
//   Mem_*               word-addressed memory port, owned by this block while Busy=1
// All outputs are registered.
module store_rmw_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Dato,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_RE,
    output logic              Mem_WE,
    output logic [31:0]       Mem_WData,
    input  logic [31:0]       Mem_RData
);

    localparam int unsigned      CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
    localparam logic [2:0]       F3_SB    = 3'b000;
    localparam logic [2:0]       F3_SH    = 3'b001;
    localparam logic [2:0]       F3_SW    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       dato_q, dato_d;
    logic              ill_q, ill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [31:0]       merged;

    // Merge the latched store data into the word returned by memory
    always_comb begin
        merged = Mem_RData;
        if (funct3_q == F3_SB) begin
            unique case (off_q)
                2'd0:    merged[7:0]   = dato_q[7:0];
                2'd1:    merged[15:8]  = dato_q[7:0];
                2'd2:    merged[23:16] = dato_q[7:0];
                default: merged[31:24] = dato_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = dato_q[15:0];
        end else begin
            merged[15:0] = dato_q[15:0];
        end
    end

    // Next state, latched request fields and next registered outputs.
    // Outputs are derived from the next state so they line up with the state.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        dato_d     = dato_q;
        ill_d      = ill_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (Req) begin
                    funct3_d   = Funct3;
                    off_d      = Addr[1:0];
                    dato_d     = Dato;
                    mem_addr_d = {Addr[ADDR_W-1:2], 2'b00};
                    ill_d      = 1'b0;
                    cnt_d      = '0;
                    if (Funct3 == F3_SW && Addr[1:0] == 2'b00) begin
                        state_d = S_WRITE;
                        wdata_d = Dato;
                    end else if (Funct3 == F3_SB || (Funct3 == F3_SH && !Addr[0])) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                        ill_d   = 1'b1;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                // Read data is valid in the last wait cycle; merge it on the way out
                if (cnt_q == LAST_CNT) begin
                    state_d = S_WRITE;
                    wdata_d = merged;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        re_d   = (state_d == S_READ);
        we_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_DONE) && ill_d;
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            funct3_q   <= '0;
            off_q      <= '0;
            dato_q     <= '0;
            ill_q      <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            dato_q     <= dato_d;
            ill_q      <= ill_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            re_q       <= re_d;
            we_q       <= we_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_RE    = re_q;
    assign Mem_WE    = we_q;
    assign Mem_WData = wdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each with its own latency-accurate memory. A reference model computes the
// expected word, strobes and cycle counts from the store rules directly.
module tb_store_rmw_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req, sel;
    logic [2:0]  f3;
    logic [31:0] addr, dato;
    logic req1, req3;

    logic busy1, done1, err1, re1, we1;
    logic busy3, done3, err3, re3, we3;
    logic [31:0] maddr1, wd1, rd1, maddr3, wd3, rd3;

    logic o_busy, o_done, o_err, o_re, o_we;
    logic [31:0] o_maddr, o_wd;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] pipe1 [4];
    logic [31:0] pipe3 [4];
    logic [31:0] ref_mem [2][16];
    logic        ld;
    logic [3:0]  ld_idx;
    logic [31:0] ld_val;

    always #5 clk = ~clk;

    assign req1 = req & ~sel;
    assign req3 = req & sel;

    store_rmw_ctrl #(.ADDR_W(32), .MEM_LAT(1)) dut1 (
        .CLK(clk), .RST(rst), .Req(req1), .Funct3(f3), .Addr(addr), .Dato(dato),
        .Busy(busy1), .Done(done1), .Err(err1), .Mem_Addr(maddr1), .Mem_RE(re1),
        .Mem_WE(we1), .Mem_WData(wd1), .Mem_RData(rd1));

    store_rmw_ctrl #(.ADDR_W(32), .MEM_LAT(3)) dut3 (
        .CLK(clk), .RST(rst), .Req(req3), .Funct3(f3), .Addr(addr), .Dato(dato),
        .Busy(busy3), .Done(done3), .Err(err3), .Mem_Addr(maddr3), .Mem_RE(re3),
        .Mem_WE(we3), .Mem_WData(wd3), .Mem_RData(rd3));

    assign o_busy  = sel ? busy3 : busy1;
    assign o_done  = sel ? done3 : done1;
    assign o_err   = sel ? err3  : err1;
    assign o_re    = sel ? re3   : re1;
    assign o_we    = sel ? we3   : we1;
    assign o_maddr = sel ? maddr3 : maddr1;
    assign o_wd    = sel ? wd3   : wd1;

    // Memories: read data appears MEM_LAT cycles after the read strobe, garbage otherwise
    always @(posedge clk) begin
        if (ld) begin
            mem1[ld_idx] <= ld_val;
            mem3[ld_idx] <= ld_val;
        end
        if (we1) mem1[maddr1[5:2]] <= wd1;
        if (we3) mem3[maddr3[5:2]] <= wd3;
        pipe1[0] <= re1 ? mem1[maddr1[5:2]] : 32'hDEAD_BEEF;
        pipe3[0] <= re3 ? mem3[maddr3[5:2]] : 32'hBAAD_F00D;
        for (int i = 1; i < 4; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe3[i] <= pipe3[i-1];
        end
    end
    assign rd1 = pipe1[0];
    assign rd3 = pipe3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Expected memory word after a legal store, from the byte-lane rules
    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] fn,
                                              input logic [1:0] k, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] val;
        int sh;
        if (fn == 3'b000) begin
            sh   = 8 * int'(k);
            mask = 32'h0000_00FF << sh;
            val  = (d & 32'h0000_00FF) << sh;
        end else if (fn == 3'b001) begin
            sh   = 16 * int'(k[1]);
            mask = 32'h0000_FFFF << sh;
            val  = (d & 32'h0000_FFFF) << sh;
        end else begin
            mask = 32'hFFFF_FFFF;
            val  = d;
        end
        return (w & ~mask) | (val & mask);
    endfunction

    task automatic load_word(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        ld = 1'b1; ld_idx = idx; ld_val = val;
        @(negedge clk);
        ld = 1'b0;
        ref_mem[0][idx] = val;
        ref_mem[1][idx] = val;
    endtask

    // One store; returns at the falling edge of the Done cycle.
    // hold=1 keeps Req high and scrambles the inputs while busy.
    task automatic do_txn(input bit s, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        bit legal;
        int lat, exp_done, exp_we_cyc, n;
        int re_cnt, we_cnt, re_cyc, we_cyc, done_cyc, overlap, bad_wd, bad_busy, bad_err;
        logic [31:0] we_data, we_addr, done_addr, exp_word, mem_now;
        logic err_seen;
        logic [3:0] idx;
        legal = (fn == 3'b000) || (fn == 3'b001 && !a[0]) || (fn == 3'b010 && a[1:0] == 2'b00);
        lat   = s ? 3 : 1;
        idx   = a[5:2];
        exp_done   = !legal ? 1 : ((fn == 3'b010) ? 2 : 3 + lat);
        exp_we_cyc = (fn == 3'b010) ? 1 : 2 + lat;
        exp_word   = legal ? ref_store(ref_mem[s][idx], fn, a[1:0], d) : ref_mem[s][idx];
        re_cnt = 0; we_cnt = 0; re_cyc = 0; we_cyc = 0; done_cyc = 0;
        overlap = 0; bad_wd = 0; bad_busy = 0; bad_err = 0;
        we_data = '0; we_addr = '0; done_addr = '0; err_seen = 1'b0;

        @(negedge clk);
        sel = s; f3 = fn; addr = a; dato = d; req = 1'b1;
        n = 0;
        while (done_cyc == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (o_re) begin re_cnt++; re_cyc = n; end
            if (o_we) begin we_cnt++; we_cyc = n; we_data = o_wd; we_addr = o_maddr; end
            if (o_re && o_we) overlap++;
            if (!o_we && o_wd != 32'h0) bad_wd++;
            if (!o_busy) bad_busy++;
            if (o_err && !o_done) bad_err++;
            if (o_done) begin done_cyc = n; err_seen = o_err; done_addr = o_maddr; end
            if (hold) begin
                addr = $urandom; dato = $urandom; f3 = 3'($urandom);
            end else begin
                req = 1'b0;
            end
        end

        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("err_flag", 32'(err_seen), 32'(!legal));
        check("re_count", 32'(re_cnt), 32'(legal && fn != 3'b010));
        check("we_count", 32'(we_cnt), 32'(legal));
        if (legal) begin
            check("we_cycle", 32'(we_cyc), 32'(exp_we_cyc));
            check("we_data", we_data, exp_word);
            check("we_addr", we_addr, {a[31:2], 2'b00});
        end
        if (legal && fn != 3'b010) check("re_cycle", 32'(re_cyc), 32'd1);
        check("re_we_overlap", 32'(overlap), 32'd0);
        check("wdata_idle_zero", 32'(bad_wd), 32'd0);
        check("busy_held", 32'(bad_busy), 32'd0);
        check("err_without_done", 32'(bad_err), 32'd0);
        check("addr_at_done", done_addr, {a[31:2], 2'b00});
        ref_mem[s][idx] = exp_word;
        mem_now = s ? mem3[idx] : mem1[idx];
        check("mem_word", mem_now, exp_word);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int we_after;
        int r;
        bit s;
        logic [2:0] fn;
        logic [31:0] a;
        rst = 1'b1; req = 1'b0; sel = 1'b0; f3 = '0; addr = '0; dato = '0;
        ld = 1'b0; ld_idx = '0; ld_val = '0;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        check("rst_busy", {30'd0, busy1, busy3}, 32'd0);
        check("rst_done_err", {28'd0, done1, err1, done3, err3}, 32'd0);
        check("rst_re_we", {28'd0, re1, we1, re3, we3}, 32'd0);
        check("rst_maddr1", maddr1, 32'd0);
        check("rst_maddr3", maddr3, 32'd0);
        check("rst_wdata", wd1 | wd3, 32'd0);
        for (int i = 0; i < 16; i++) load_word(4'(i), $urandom);
        @(negedge clk);
        rst = 1'b0;

        // Directed: SW, SB on all lanes, SH both halves, illegal forms
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b0, 3'b010, 32'h100, 32'hABCD_EF17, 1'b0);
        for (int k = 0; k < 4; k++) begin
            load_word(4'd0, 32'h1122_3344);
            do_txn(1'b0, 3'b000, 32'h100 + 32'(k), 32'hABCD_EF17, 1'b0);
        end
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b0, 3'b001, 32'h100, 32'hABCD_EF17, 1'b0);
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b0, 3'b001, 32'h102, 32'hABCD_EF17, 1'b0);
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b0, 3'b001, 32'h103, 32'hABCD_EF17, 1'b0);
        do_txn(1'b0, 3'b010, 32'h102, 32'hABCD_EF17, 1'b0);
        do_txn(1'b0, 3'b100, 32'h100, 32'hABCD_EF17, 1'b0);

        // Req held with changing inputs, then a back-to-back SW accepted after DONE
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b0, 3'b000, 32'h102, 32'hABCD_EF17, 1'b1);
        f3 = 3'b010; addr = 32'h104; dato = 32'hCAFE_0001;
        @(negedge clk);
        check("b2b_idle_gap", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("b2b_busy", 32'(o_busy), 32'd1);
        check("b2b_we", 32'(o_we), 32'd1);
        check("b2b_addr", o_maddr, 32'h104);
        check("b2b_wdata", o_wd, 32'hCAFE_0001);
        req = 1'b0;
        @(negedge clk);
        check("b2b_done", 32'(o_done), 32'd1);
        ref_mem[0][1] = 32'hCAFE_0001;
        check("b2b_mem", mem1[1], 32'hCAFE_0001);

        // Reset during WAIT drops the pending write
        load_word(4'd0, 32'h1122_3344);
        @(negedge clk);
        sel = 1'b0; f3 = 3'b000; addr = 32'h101; dato = 32'h0000_0055; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("rst_mid_read", 32'(o_re), 32'd1);
        @(negedge clk);
        check("rst_mid_wait_busy", {30'd0, o_busy, o_re}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", {27'd0, busy1, done1, err1, re1, we1}, 32'd0);
        check("rst_mid_maddr", maddr1, 32'd0);
        check("rst_mid_wdata", wd1, 32'd0);
        we_after = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            if (we1 || we3) we_after++;
        end
        check("rst_no_we_after", 32'(we_after), 32'd0);
        check("rst_mem_kept", mem1[0], 32'h1122_3344);
        do_txn(1'b0, 3'b010, 32'h100, 32'h7654_3210, 1'b0);

        // MEM_LAT=3 instance
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b1, 3'b000, 32'h101, 32'hABCD_EF17, 1'b0);
        load_word(4'd0, 32'h1122_3344);
        do_txn(1'b1, 3'b001, 32'h102, 32'hABCD_EF17, 1'b0);

        // Random mix over both instances
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            s = 1'($urandom_range(0, 1));
            a = 32'h100 + $urandom_range(0, 63);
            if (r < 4)      fn = 3'b000;
            else if (r < 7) fn = 3'b001;
            else if (r < 9) fn = 3'b010;
            else            fn = 3'($urandom_range(3, 7));
            if (fn == 3'b010 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_txn(s, fn, a, $urandom, 1'($urandom_range(0, 1)));
            req = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
